piso_frame_tx: RTL and testbench

PISO_FRAME_TX -- requirements
Module: piso_frame_tx

---
 rtl/piso_frame_tx.sv | 116 +++++++++++
 tb/tb_piso_frame_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/piso_frame_tx.sv
// rtl/piso_frame_tx.sv - parallel-in serial-out frame transmitter
// Frame: start(0), WIDTH payload bits LSB first, optional even parity, stop(1).
module piso_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             data_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             data_out_q, data_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  // ready comes from the state register alone so load never feeds back into it
  assign ready      = (state_q == IDLE) || (state_q == STOP);
  assign accept     = load && ready;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      parity_q   <= 1'b0;
      data_out_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      parity_q   <= parity_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are registered, so each branch sets the line level of the state being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    parity_d   = parity_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          state_d    = START;
          shift_d    = data_in;
          parity_d   = ^data_in;
          cnt_d      = '0;
          data_out_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = IDLE;
          data_out_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      START: begin
        state_d    = DATA;
        data_out_d = shift_q[0];
        shift_d    = shift_q >> 1;
        cnt_d      = '0;
      end
      DATA: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (PARITY_EN != 0) begin
            state_d    = PARITY;
            data_out_d = parity_q;
          end else begin
            state_d    = STOP;
            data_out_d = 1'b1;
            done_d     = 1'b1;
          end
        end else begin
          data_out_d = shift_q[0];
          shift_d    = shift_q >> 1;
          cnt_d      = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d    = STOP;
        data_out_d = 1'b1;
        done_d     = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        data_out_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// tb/tb_piso_frame_tx.sv - directed bench for piso_frame_tx
// Two instances: parity enabled and parity disabled, both WIDTH=8.
module tb_piso_frame_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in, data_in_np;
  logic       load, load_np;
  logic       ready, data_out, busy, frame_done;
  logic       ready_np, data_out_np, busy_np, frame_done_np;
  int         checks;
  int         errors;

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(0)) dut_np (
    .clk(clk), .rst(rst), .data_in(data_in_np), .load(load_np),
    .ready(ready_np), .data_out(data_out_np), .busy(busy_np), .frame_done(frame_done_np)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input bit np);
    if (np) begin
      chk({tag, "_do"},    data_out_np,   1'b1);
      chk({tag, "_busy"},  busy_np,       1'b0);
      chk({tag, "_rdy"},   ready_np,      1'b1);
      chk({tag, "_done"},  frame_done_np, 1'b0);
    end else begin
      chk({tag, "_do"},    data_out,      1'b1);
      chk({tag, "_busy"},  busy,          1'b0);
      chk({tag, "_rdy"},   ready,         1'b1);
      chk({tag, "_done"},  frame_done,    1'b0);
    end
  endtask

  // Called in the first cycle after the accepting edge; seq[k] is the line level in cycle k.
  // At cycle poke_k, load is pulsed with poke_d on the parity instance.
  task automatic frame(input string tag, input string seq, input bit np,
                       input int poke_k, input logic [7:0] poke_d);
    int   n;
    logic e;
    n = seq.len();
    for (int k = 0; k < n; k++) begin
      e = (seq[k] == 8'h31);
      if (np) begin
        chk($sformatf("%s_do%0d", tag, k),   data_out_np,   e);
        chk($sformatf("%s_busy%0d", tag, k), busy_np,       1'b1);
        chk($sformatf("%s_done%0d", tag, k), frame_done_np, (k == n - 1));
        chk($sformatf("%s_rdy%0d", tag, k),  ready_np,      (k == n - 1));
      end else begin
        chk($sformatf("%s_do%0d", tag, k),   data_out,      e);
        chk($sformatf("%s_busy%0d", tag, k), busy,          1'b1);
        chk($sformatf("%s_done%0d", tag, k), frame_done,    (k == n - 1));
        chk($sformatf("%s_rdy%0d", tag, k),  ready,         (k == n - 1));
      end
      if (k == poke_k) begin
        load    = 1'b1;
        data_in = poke_d;
      end
      step();
      if (k == poke_k) load = 1'b0;
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    load       = 1'b0;
    load_np    = 1'b0;
    data_in    = 8'h00;
    data_in_np = 8'h00;
    checks     = 0;
    errors     = 0;

    step();
    step();
    chk_idle("reset", 1'b0);
    chk_idle("reset_np", 1'b1);
    rst = 1'b0;
    step();
    chk_idle("idle", 1'b0);

    // single A5 frame, parity 0
    load = 1'b1; data_in = 8'hA5;
    step();
    load = 1'b0; data_in = 8'h00;
    frame("a5", "01010010101", 1'b0, -1, 8'h00);
    chk_idle("a5_after", 1'b0);

    // 07 has odd weight, parity bit 1; data_in churns after capture
    load = 1'b1; data_in = 8'h07;
    step();
    load = 1'b0; data_in = 8'hF8;
    frame("p07", "01110000011", 1'b0, -1, 8'h00);
    chk_idle("p07_after", 1'b0);

    // back-to-back: 3C loaded in the STOP cycle of A5
    load = 1'b1; data_in = 8'hA5;
    step();
    load = 1'b0;
    frame("b2b_a5", "01010010101", 1'b0, 10, 8'h3C);
    data_in = 8'h00;
    frame("b2b_3c", "00011110001", 1'b0, -1, 8'h00);
    chk_idle("b2b_after", 1'b0);

    // FF pulsed during DATA cycle 3 must be ignored
    load = 1'b1; data_in = 8'hA5;
    step();
    load = 1'b0;
    frame("busyld", "01010010101", 1'b0, 4, 8'hFF);
    chk_idle("busyld_after", 1'b0);
    step();
    chk_idle("busyld_after2", 1'b0);

    // reset in DATA cycle 4 aborts the frame
    load = 1'b1; data_in = 8'hA5;
    step();
    load = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("midrst_busy_pre", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst", 1'b0);
    step();
    chk_idle("midrst2", 1'b0);
    load = 1'b1; data_in = 8'h5A;
    step();
    load = 1'b0;
    frame("p5a", "00101101001", 1'b0, -1, 8'h00);
    chk_idle("p5a_after", 1'b0);

    // reset wins over a simultaneous load
    rst = 1'b1; load = 1'b1; data_in = 8'h00;
    step();
    rst = 1'b0; load = 1'b0;
    chk_idle("rstld", 1'b0);
    step();
    chk_idle("rstld2", 1'b0);

    // no-parity instance: 10-cycle frame
    load_np = 1'b1; data_in_np = 8'hA5;
    step();
    load_np = 1'b0; data_in_np = 8'h00;
    frame("np", "0101001011", 1'b1, -1, 8'h00);
    chk_idle("np_after", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
